// File: rtl/niosii_analog_capture_pio.sv
// niosii_analog_capture_pio: multi-channel ADC scanner with a sample FIFO, irq and a live-value register.
// Define ANALOG_PIO_INPUT_SYNC_EN to put a two-flop synchronizer in front of in_port.
module niosii_analog_capture_pio #(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 1000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2:0]               address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    output logic                     irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 3 + DATA_W;
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [NUM_CH*DATA_W-1:0] in_s;
`ifdef ANALOG_PIO_INPUT_SYNC_EN
    logic [NUM_CH*DATA_W-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end
    assign in_s = sync2_q;
`else
    assign in_s = in_port;
`endif

    // Channel table padded to 8 so any 3-bit select is in range; absent channels read 0.
    logic [DATA_W-1:0] ch [8];
    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            assign ch[c] = in_s[c*DATA_W +: DATA_W];
        end else begin : g_off
            assign ch[c] = '0;
        end
    end

    logic              en_q, irq_en_q, ovf_q, irq_q;
    logic [2:0]        sel_q, scan_q, scan_d;
    logic [31:0]       div_q, cnt_q, cnt_d, rdata_q, rdata_d;
    logic [8:0]        thresh_q;
    logic [AW-1:0]     wr_q, rd_q, wr_d, rd_d;
    logic [LW-1:0]     level_q, level_d;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [EW-1:0]     head;
    logic [31:0]       pop_word;
    logic              wr_ctrl, wr_stat, wr_div, wr_thr, flush, empty, full;
    logic              tick, pop, push_req, push, drop, ovf_d, irq_d;

    assign wr_ctrl  = write && address == 3'd1;
    assign wr_stat  = write && address == 3'd2;
    assign wr_div   = write && address == 3'd4;
    assign wr_thr   = write && address == 3'd5;
    assign flush    = wr_ctrl && writedata[2];
    assign empty    = level_q == '0;
    assign full     = level_q == FULL_LVL;
    assign head     = mem[rd_q];
    assign tick     = en_q && cnt_q == div_q;
    assign pop      = read && address == 3'd3 && !empty;
    assign push_req = tick && !flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign pop_word = empty ? '0 : {1'b1, 12'b0, head[EW-1 -: 3], 16'(head[DATA_W-1:0])};

    always_comb begin
        cnt_d   = (!en_q || wr_div || tick) ? '0 : cnt_q + 32'd1;
        scan_d  = (!en_q || wr_div) ? '0 : tick ? (scan_q == LAST_CH ? '0 : scan_q + 3'd1) : scan_q;
        level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
        wr_d    = flush ? '0 : wr_q + AW'(push);
        rd_d    = flush ? '0 : rd_q + AW'(pop);
        ovf_d   = drop | (ovf_q & ~(wr_stat & writedata[18]));
        irq_d   = irq_en_q & ((9'(level_q) >= thresh_q && thresh_q != '0) | ovf_q);
        rdata_d = '0;
        case (address)
            3'd0:    rdata_d = 32'(ch[sel_q]);
            3'd1:    rdata_d = {21'b0, sel_q, 6'b0, irq_en_q, en_q};
            3'd2:    rdata_d = {13'b0, ovf_q, full, empty, 7'b0, 9'(level_q)};
            3'd3:    rdata_d = pop_word;
            3'd4:    rdata_d = div_q;
            3'd5:    rdata_d = {23'b0, thresh_q};
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            sel_q    <= '0;
            div_q    <= 32'(DIV_RESET);
            thresh_q <= 9'(FIFO_DEPTH / 2);
            cnt_q    <= '0;
            scan_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= writedata[0];
                irq_en_q <= writedata[1];
                sel_q    <= writedata[10:8];
            end
            if (wr_div) div_q <= writedata;
            if (wr_thr) thresh_q <= writedata[8:0];
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= {scan_q, ch[scan_q]};
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_niosii_analog_capture_pio.sv
// tb_niosii_analog_capture_pio: directed register-level checks of the capture PIO.
module tb_niosii_analog_capture_pio;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [23:0] in_port = 24'h332211;
    logic        irq;
    logic [31:0] d;
    int          n_chk = 0;
    int          n_fail = 0;

    niosii_analog_capture_pio dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        address = a; writedata = v; write = 1'b1;
        idle(1);
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a; read = 1'b1;
        idle(1);
        read = 1'b0;
        v = readdata;
    endtask

    initial begin
        idle(3);
        reset_n = 1'b1;
        check("rst_rdata", readdata, 0);
        check("rst_irq", {31'b0, irq}, 0);
        rd(1, d); check("rst_ctrl", d, 0);
        rd(4, d); check("rst_div", d, 1000);
        rd(5, d); check("rst_thresh", d, 8);
        rd(2, d); check("rst_status", d, 32'h0001_0000);
        rd(3, d); check("rst_pop", d, 0);
        rd(0, d); check("rst_live", d, 32'h11);

        // three ticks with DIV=3 over 12 clocks
        wr(4, 3); wr(1, 1);
        idle(12);
        wr(1, 0);
        rd(2, d); check("scan_level", d, 3);
        rd(3, d); check("scan_pop0", d, 32'h8000_0011);
        rd(3, d); check("scan_pop1", d, 32'h8001_0022);
        rd(3, d); check("scan_pop2", d, 32'h8002_0033);
        rd(3, d); check("scan_pop_empty", d, 0);
        check("scan_irq", {31'b0, irq}, 0);

        // overflow, clear and flush
        wr(4, 0); wr(1, 1);
        idle(20);
        wr(1, 3); wr(1, 2);
        rd(2, d); check("ovf_status", d, 32'h0006_0010);
        check("ovf_irq", {31'b0, irq}, 1);
        wr(2, 32'h0004_0000);
        rd(2, d); check("ovf_cleared", d, 32'h0002_0010);
        wr(1, 6);
        check("flush_irq_lag", {31'b0, irq}, 1);
        rd(2, d); check("flush_status", d, 32'h0001_0000);
        check("flush_irq_drop", {31'b0, irq}, 0);

        // full FIFO, pop every clock: irq (THRESH=0) tracks overflow only
        wr(5, 0); wr(1, 3);
        idle(16);
        check("full_irq", {31'b0, irq}, 0);
        for (int i = 0; i < 6; i++) begin
            rd(3, d);
            check($sformatf("stream_pop%0d", i), d, 32'h8000_0000 | ((i % 3) << 16) | (32'h11 * (i % 3 + 1)));
            check($sformatf("stream_irq%0d", i), {31'b0, irq}, 0);
        end
        wr(1, 2);
        rd(2, d); check("stream_end_status", d, 32'h0006_0010);
        check("stream_end_irq", {31'b0, irq}, 1);
        wr(2, 32'h0004_0000); wr(1, 6);

        // threshold irq with DIV=9
        wr(5, 4); wr(4, 9); wr(1, 3);
        idle(40);
        check("thr_irq_lag", {31'b0, irq}, 0);
        idle(1);
        check("thr_irq_rise", {31'b0, irq}, 1);
        wr(1, 2);
        rd(3, d); check("thr_pop", d, 32'h8000_0011);
        check("thr_irq_hold", {31'b0, irq}, 1);
        idle(1);
        check("thr_irq_fall", {31'b0, irq}, 0);
        rd(2, d); check("thr_level", d, 3);

        // reset mid-scan with level 5
        wr(4, 0); wr(1, 3);
        idle(2);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        check("mid_rst_rdata", readdata, 0);
        check("mid_rst_irq", {31'b0, irq}, 0);
        rd(2, d); check("mid_rst_status", d, 32'h0001_0000);
        rd(4, d); check("mid_rst_div", d, 1000);
        wr(4, 0); wr(1, 1); wr(1, 0);
        rd(3, d); check("mid_rst_scan0", d, 32'h8000_0011);

        // live register, channel select and unmapped addresses
        wr(1, 32'h200);
        rd(0, d); check("live_ch2", d, 32'h33);
        in_port = 24'h5A2211;
`ifdef ANALOG_PIO_INPUT_SYNC_EN
        idle(2);
`endif
        rd(0, d); check("live_step", d, 32'h5A);
        wr(1, 32'h700);
        rd(0, d); check("live_ch7", d, 0);
        wr(6, 32'hFFFF_FFFF);
        rd(6, d); check("addr6", d, 0);
        rd(7, d); check("addr7", d, 0);
        rd(1, d); check("ctrl_rb", d, 32'h700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
